// File: rtl/iguana_fixture_pkg.sv
// Iguana bench fixture: shared types and constants.
// Holds the boot/preload mode encodings, the sequencer state type and the
// fixed register addresses and exit codes used on the chip memory port.
package iguana_fixture_pkg;

    // Chip boot-mode pins.
    typedef enum logic [1:0] {
        BOOT_PRELOAD = 2'd0,
        BOOT_SD      = 2'd1,
        BOOT_AUTO0   = 2'd2,
        BOOT_AUTO1   = 2'd3
    } boot_mode_e;

    // Preload channel; the value doubles as the mem-port channel select.
    typedef enum logic [1:0] {
        PMODE_JTAG  = 2'd0,
        PMODE_SLINK = 2'd1,
        PMODE_UART  = 2'd2,
        PMODE_RSVD  = 2'd3
    } preload_mode_e;

    // Sequencer states. ENTRY and WAKE are the two launch writes after the image.
    typedef enum logic [3:0] {
        ST_RST   = 4'd0,
        ST_IDLE  = 4'd1,
        ST_SDLY  = 4'd2,
        ST_LOAD  = 4'd3,
        ST_ENTRY = 4'd4,
        ST_WAKE  = 4'd5,
        ST_POLL  = 4'd6,
        ST_DONE  = 4'd7,
        ST_ERR   = 4'd8
    } state_e;

    localparam logic [63:0] ENTRY_ADDR   = 64'h0000_0000_0300_0000;
    localparam logic [63:0] WAKE_ADDR    = 64'h0000_0000_0300_0004;
    localparam logic [63:0] SCRATCH_ADDR = 64'h0000_0000_0300_0008;

    localparam logic [31:0] EXIT_ERR     = 32'hFFFF_FFFF;
    localparam logic [31:0] EXIT_TIMEOUT = 32'hDEAD_0001;

endpackage

// File: rtl/iguana_fixture_eoc_poller.sv
// EOC poller for the Iguana bench fixture.
// While active_i is high, waits PollInterval cycles, issues one read request
// of the EOC scratch register, waits for the read data, then restarts the
// interval. A returned word with bit 0 set is an end-of-computation report.
// Optional feature macro: IGUANA_FIXTURE_TIMEOUT_EN adds a 2^24-cycle watchdog.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   active_i           high while the sequencer is in POLL; low clears everything
//   mem_gnt_i          grant for the read request
//   mem_rvalid_i       read data valid
//   mem_rdata_i [32]   read data
//   req_o              read request (held until granted)
//   eoc_hit_o          read data carries EOC (valid for the rvalid cycle)
//   eoc_code_o [32]    exit code carried by the EOC word
//   timeout_o          watchdog expired (always 0 without the macro)
module iguana_fixture_eoc_poller #(
    parameter int PollInterval = 64
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        active_i,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        req_o,
    output logic        eoc_hit_o,
    output logic [31:0] eoc_code_o,
    output logic        timeout_o
);

    localparam int CW = $clog2(PollInterval + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(PollInterval - 1);

    logic [CW-1:0] cnt_q;
    logic          req_q;
    logic          wait_rv_q;

    // One access in flight at most: the interval counter only runs while
    // neither a request nor its read data is outstanding.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            req_q     <= 1'b0;
            wait_rv_q <= 1'b0;
        end else if (!active_i) begin
            cnt_q     <= '0;
            req_q     <= 1'b0;
            wait_rv_q <= 1'b0;
        end else if (req_q) begin
            if (mem_gnt_i) begin
                req_q     <= 1'b0;
                wait_rv_q <= 1'b1;
            end
        end else if (wait_rv_q) begin
            if (mem_rvalid_i) begin
                wait_rv_q <= 1'b0;
                cnt_q     <= '0;
            end
        end else if (cnt_q == CNT_LAST) begin
            req_q <= 1'b1;
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign req_o      = req_q;
    assign eoc_hit_o  = wait_rv_q && mem_rvalid_i && mem_rdata_i[0];
    assign eoc_code_o = {1'b0, mem_rdata_i[31:1]};

`ifdef IGUANA_FIXTURE_TIMEOUT_EN
    logic [23:0] wd_cnt_q;

    // Saturates at all-ones, which is reached 2^24-1 cycles into POLL; the
    // sequencer leaves on the following edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wd_cnt_q <= '0;
        end else if (!active_i) begin
            wd_cnt_q <= '0;
        end else if (wd_cnt_q != '1) begin
            wd_cnt_q <= wd_cnt_q + 24'd1;
        end
    end

    assign timeout_o = active_i && (wd_cnt_q == '1);
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: rtl/iguana_fixture.sv
// Iguana bench fixture boot/preload sequencer.
// Holds the chip in reset for RstCycles, then on start_i either streams a
// preload image over the selected channel and launches it (entry + wake
// writes), or goes straight to EOC polling for autonomous boot modes.
// Unsupported modes (SD boot, reserved preload) end in a sticky error.
// Optional feature macro: IGUANA_FIXTURE_TIMEOUT_EN (POLL watchdog, in the poller).
// Handshakes: a transfer happens on a clock edge where valid (ld_valid_i /
// mem_req_o) and ready (ld_ready_o / mem_gnt_i) are both high; the initiator
// holds its payload stable until that edge. Read data returns on mem_rvalid_i.
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   boot_mode_i, preload_mode_i   mode selection, sampled at start_i
//   start_i                       one-cycle start pulse (IDLE only)
//   chip_rst_no, boot_mode_o      chip reset (active low) and boot pins
//   chan_sel_o                    channel owning the mem port
//   ld_*                          preload word stream
//   mem_*                         chip memory port (one outstanding access)
//   done_o, error_o, exit_code_o  sticky result
//   state_o                       current sequencer state (debug)
module iguana_fixture
    import iguana_fixture_pkg::*;
#(
    parameter int AddrWidth    = 64,
    parameter int RstCycles    = 16,
    parameter int SlinkDelay   = 60035,
    parameter int PollInterval = 64,
    parameter logic [AddrWidth-1:0] ScratchAddr = AddrWidth'(SCRATCH_ADDR),
    parameter logic [AddrWidth-1:0] EntryAddr   = AddrWidth'(ENTRY_ADDR),
    parameter logic [AddrWidth-1:0] WakeAddr    = AddrWidth'(WAKE_ADDR)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [1:0]           boot_mode_i,
    input  logic [1:0]           preload_mode_i,
    input  logic                 start_i,
    output logic                 chip_rst_no,
    output logic [1:0]           boot_mode_o,
    output logic [1:0]           chan_sel_o,
    input  logic                 ld_valid_i,
    output logic                 ld_ready_o,
    input  logic [AddrWidth-1:0] ld_addr_i,
    input  logic [31:0]          ld_data_i,
    input  logic                 ld_last_i,
    input  logic [AddrWidth-1:0] ld_entry_i,
    output logic                 mem_req_o,
    input  logic                 mem_gnt_i,
    output logic                 mem_we_o,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic [31:0]          mem_wdata_o,
    input  logic                 mem_rvalid_i,
    input  logic [31:0]          mem_rdata_i,
    output logic                 done_o,
    output logic [31:0]          exit_code_o,
    output logic                 error_o,
    output state_e               state_o
);

    localparam int RW = $clog2(RstCycles + 1);
    localparam int DW = $clog2(SlinkDelay + 1);
    localparam logic [RW-1:0] RST_LAST = RW'(RstCycles - 1);
    localparam logic [DW-1:0] DLY_LAST = DW'(SlinkDelay - 1);

    state_e state_q, state_d;

    logic [RW-1:0]        rst_cnt_q;
    logic [DW-1:0]        dly_cnt_q;
    logic                 chip_rst_q;
    logic [1:0]           boot_mode_q;
    logic [1:0]           chan_q, chan_d;
    logic                 wr_req_q;
    logic [AddrWidth-1:0] wr_addr_q;
    logic [31:0]          wr_data_q;
    logic                 last_q;
    logic [31:0]          entry_q;
    logic                 done_q, error_q;
    logic [31:0]          exit_q;

    logic        ld_accept, issue_entry, issue_wake, enter_err, finish_ok;
    logic [31:0] err_code;

    logic        poll_active, poll_req, eoc_hit, poll_timeout;
    logic [31:0] eoc_code;

    // Only the low word of the entry point is written to the entry register.
    logic unused_entry_hi;
    assign unused_entry_hi = ^ld_entry_i[AddrWidth-1:32];

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_RST;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        chan_d      = 2'd0;
        ld_accept   = 1'b0;
        issue_entry = 1'b0;
        issue_wake  = 1'b0;
        enter_err   = 1'b0;
        finish_ok   = 1'b0;
        err_code    = EXIT_ERR;
        unique case (state_q)
            ST_RST: begin
                if (rst_cnt_q == RST_LAST) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (start_i) begin
                    unique case (boot_mode_e'(boot_mode_i))
                        BOOT_PRELOAD: begin
                            unique case (preload_mode_e'(preload_mode_i))
                                PMODE_JTAG, PMODE_UART: begin
                                    state_d = ST_LOAD;
                                    chan_d  = preload_mode_i;
                                end
                                PMODE_SLINK: begin
                                    state_d = ST_SDLY;
                                    chan_d  = preload_mode_i;
                                end
                                default: begin
                                    state_d   = ST_ERR;
                                    enter_err = 1'b1;
                                end
                            endcase
                        end
                        BOOT_SD: begin
                            state_d   = ST_ERR;
                            enter_err = 1'b1;
                        end
                        default: state_d = ST_POLL;
                    endcase
                end
            end
            ST_SDLY: begin
                if (dly_cnt_q == DLY_LAST) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                ld_accept = ld_valid_i && !wr_req_q;
                // Grant of the last image word chains straight into the entry write.
                if (wr_req_q && mem_gnt_i && last_q) begin
                    issue_entry = 1'b1;
                    state_d     = ST_ENTRY;
                end
            end
            ST_ENTRY: begin
                if (mem_gnt_i) begin
                    issue_wake = 1'b1;
                    state_d    = ST_WAKE;
                end
            end
            ST_WAKE: begin
                if (mem_gnt_i) state_d = ST_POLL;
            end
            ST_POLL: begin
                if (eoc_hit) begin
                    finish_ok = 1'b1;
                    state_d   = ST_DONE;
                end else if (poll_timeout) begin
                    enter_err = 1'b1;
                    err_code  = EXIT_TIMEOUT;
                    state_d   = ST_ERR;
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------- datapath regs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rst_cnt_q   <= '0;
            dly_cnt_q   <= '0;
            chip_rst_q  <= 1'b0;
            boot_mode_q <= 2'd0;
            chan_q      <= 2'd0;
            wr_req_q    <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            last_q      <= 1'b0;
            entry_q     <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            exit_q      <= '0;
        end else begin
            if (state_q == ST_RST) begin
                rst_cnt_q   <= rst_cnt_q + RW'(1);
                boot_mode_q <= boot_mode_i;
                if (rst_cnt_q == RST_LAST) chip_rst_q <= 1'b1;
            end

            if (state_q == ST_SDLY) dly_cnt_q <= dly_cnt_q + DW'(1);
            else                    dly_cnt_q <= '0;

            if (state_q == ST_IDLE && start_i) chan_q <= chan_d;

            if (ld_accept) begin
                wr_req_q  <= 1'b1;
                wr_addr_q <= ld_addr_i;
                wr_data_q <= ld_data_i;
                last_q    <= ld_last_i;
                if (ld_last_i) entry_q <= ld_entry_i[31:0];
            end else if (issue_entry) begin
                wr_addr_q <= EntryAddr;
                wr_data_q <= entry_q;
            end else if (issue_wake) begin
                wr_addr_q <= WakeAddr;
                wr_data_q <= 32'd1;
            end else if (wr_req_q && mem_gnt_i) begin
                wr_req_q <= 1'b0;
            end

            if (finish_ok) begin
                done_q <= 1'b1;
                exit_q <= eoc_code;
            end
            if (enter_err) begin
                error_q <= 1'b1;
                exit_q  <= err_code;
            end
        end
    end

    // ------------------------------------------------------------ poller
    assign poll_active = (state_q == ST_POLL);

    iguana_fixture_eoc_poller #(
        .PollInterval (PollInterval)
    ) u_poller (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .active_i     (poll_active),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .req_o        (poll_req),
        .eoc_hit_o    (eoc_hit),
        .eoc_code_o   (eoc_code),
        .timeout_o    (poll_timeout)
    );

    // ----------------------------------------------------------- outputs
    // Writes and scratch reads never overlap in time, so the port is a
    // simple state-selected mux.
    assign mem_req_o   = poll_active ? poll_req    : wr_req_q;
    assign mem_we_o    = !poll_active && wr_req_q;
    assign mem_addr_o  = poll_active ? ScratchAddr : wr_addr_q;
    assign mem_wdata_o = poll_active ? 32'h0       : wr_data_q;

    assign ld_ready_o  = (state_q == ST_LOAD) && !wr_req_q;
    assign chip_rst_no = chip_rst_q;
    assign boot_mode_o = boot_mode_q;
    assign chan_sel_o  = chan_q;
    assign done_o      = done_q;
    assign error_o     = error_q;
    assign exit_code_o = exit_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_iguana_fixture.sv
// Testbench for iguana_fixture: random preload images and scratch responses,
// a memory responder with random grant latency, and an ordered scoreboard of
// expected memory-port accesses.
module tb_iguana_fixture;
    import iguana_fixture_pkg::*;

    localparam int RST_CYCLES    = 16;
    localparam int SLINK_DELAY   = 200;
    localparam int POLL_INTERVAL = 16;
    localparam logic [63:0] ENTRY_A   = 64'h0300_0000;
    localparam logic [63:0] WAKE_A    = 64'h0300_0004;
    localparam logic [63:0] SCRATCH_A = 64'h0300_0008;

    // ------------------------------------------------ clock / reset / DUT
    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [1:0]  boot_mode_i, preload_mode_i;
    logic        start_i;
    logic        chip_rst_no;
    logic [1:0]  boot_mode_o, chan_sel_o;
    logic        ld_valid_i, ld_ready_o, ld_last_i;
    logic [63:0] ld_addr_i, ld_entry_i;
    logic [31:0] ld_data_i;
    logic        mem_req_o, mem_gnt_i, mem_we_o, mem_rvalid_i;
    logic [63:0] mem_addr_o;
    logic [31:0] mem_wdata_o, mem_rdata_i;
    logic        done_o, error_o;
    logic [31:0] exit_code_o;
    state_e      dbg_state;

    always #5 clk_i = ~clk_i;

    iguana_fixture #(
        .AddrWidth    (64),
        .RstCycles    (RST_CYCLES),
        .SlinkDelay   (SLINK_DELAY),
        .PollInterval (POLL_INTERVAL)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .boot_mode_i    (boot_mode_i),
        .preload_mode_i (preload_mode_i),
        .start_i        (start_i),
        .chip_rst_no    (chip_rst_no),
        .boot_mode_o    (boot_mode_o),
        .chan_sel_o     (chan_sel_o),
        .ld_valid_i     (ld_valid_i),
        .ld_ready_o     (ld_ready_o),
        .ld_addr_i      (ld_addr_i),
        .ld_data_i      (ld_data_i),
        .ld_last_i      (ld_last_i),
        .ld_entry_i     (ld_entry_i),
        .mem_req_o      (mem_req_o),
        .mem_gnt_i      (mem_gnt_i),
        .mem_we_o       (mem_we_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_rdata_i    (mem_rdata_i),
        .done_o         (done_o),
        .exit_code_o    (exit_code_o),
        .error_o        (error_o),
        .state_o        (dbg_state)
    );

    // ---------------------------------------------------------- scoreboard
    // Access record: {we, addr[63:0], wdata[31:0]}
    logic [96:0] exp_q[$];
    logic [96:0] obs_q[$];
    logic [31:0] resp_q[$];
    logic [63:0] img_a_q[$];
    logic [31:0] img_d_q[$];
    int checks   = 0;
    int failures = 0;
    int stall_next = 0;
    int gap;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Memory responder: random grant latency, read data one cycle after grant.
    logic [96:0] cur_txn;
    bit          have_req, rd_pend, stall_chk;
    int          wait_cnt;

    initial begin
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        have_req = 0; rd_pend = 0; stall_chk = 0; wait_cnt = 0;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
                have_req = 0; rd_pend = 0; stall_chk = 0;
            end else begin
                mem_rvalid_i = 1'b0;
                if (rd_pend) begin
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i  = (resp_q.size() > 0) ? resp_q.pop_front() : 32'h0;
                    rd_pend = 0;
                end
                if (mem_gnt_i) begin
                    mem_gnt_i = 1'b0;
                    have_req = 0;
                    stall_chk = 0;
                end else if (mem_req_o) begin
                    if (!have_req) begin
                        have_req = 1;
                        cur_txn = {mem_we_o, mem_addr_o, mem_wdata_o};
                        if (stall_next > 0) begin
                            wait_cnt = stall_next; stall_next = 0; stall_chk = 1;
                        end else begin
                            wait_cnt = $urandom_range(0, 2);
                        end
                    end else begin
                        check("req_stable", {mem_we_o, mem_addr_o, mem_wdata_o}, cur_txn);
                        if (stall_chk) check("ld_ready_in_stall", ld_ready_o, 1'b0);
                    end
                    if (wait_cnt == 0) begin
                        mem_gnt_i = 1'b1;
                        obs_q.push_back(cur_txn);
                        if (!cur_txn[96]) rd_pend = 1;
                    end else begin
                        wait_cnt--;
                    end
                end
            end
        end
    end

    // Monitor: every granted access is compared in order with the plan.
    initial begin
        logic [96:0] t, e;
        forever begin
            @(posedge clk_i);
            #2;
            while (obs_q.size() > 0) begin
                t = obs_q.pop_front();
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_access actual=%0h required=none", t);
                end else begin
                    e = exp_q.pop_front();
                    if (e[96]) check("mem_write", t, e);
                    else       check("mem_read", t[96:32], e[96:32]);
                end
            end
        end
    end

    // --------------------------------------------------------- reference
    // Image plan: every word written in order, then entry low word, then 1 to wake.
    task automatic plan_load(input int n, input logic [63:0] entry);
        img_a_q.delete(); img_d_q.delete();
        for (int i = 0; i < n; i++) begin
            img_a_q.push_back({$urandom, $urandom & 32'hFFFF_FFFC});
            img_d_q.push_back($urandom);
            exp_q.push_back({1'b1, img_a_q[i], img_d_q[i]});
        end
        exp_q.push_back({1'b1, ENTRY_A, entry[31:0]});
        exp_q.push_back({1'b1, WAKE_A, 32'd1});
    endtask

    // Poll plan: nzero non-EOC responses then one EOC word; exit = word / 2.
    task automatic plan_poll(input int nzero, input logic [31:0] eoc_word, input bit rnd,
                             output logic [31:0] exit_code);
        for (int i = 0; i < nzero; i++) begin
            resp_q.push_back(rnd ? ($urandom & 32'hFFFF_FFFE) : 32'h0);
            exp_q.push_back({1'b0, SCRATCH_A, 32'h0});
        end
        resp_q.push_back(eoc_word | 32'h1);
        exp_q.push_back({1'b0, SCRATCH_A, 32'h0});
        exit_code = (eoc_word | 32'h1) / 2;
    endtask

    // ------------------------------------------------------------ drivers
    task automatic do_reset();
        int k;
        @(negedge clk_i);
        rst_ni = 1'b0; start_i = 1'b0; ld_valid_i = 1'b0; ld_last_i = 1'b0;
        repeat (2) @(negedge clk_i);
        exp_q.delete(); obs_q.delete(); resp_q.delete(); stall_next = 0;
        check("reset_outs", {chip_rst_no, boot_mode_o, chan_sel_o, mem_req_o, ld_ready_o,
                             done_o, error_o, exit_code_o}, '0);
        rst_ni = 1'b1;
        k = 0;
        while (chip_rst_no !== 1'b1 && k < 200) begin
            @(negedge clk_i);
            k++;
        end
        check("chip_rst_len", k, RST_CYCLES);
        check("boot_mode_o", boot_mode_o, boot_mode_i);
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    task automatic send_word(input logic [63:0] a, input logic [31:0] d, input bit last,
                             input logic [63:0] entry);
        int n;
        ld_valid_i = 1'b1; ld_addr_i = a; ld_data_i = d; ld_last_i = last;
        ld_entry_i = last ? entry : {$urandom, $urandom};
        n = 0;
        while (!ld_ready_o && n < 2000) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 2000) begin
            checks++; failures++;
            $display("FAIL ld_accept_timeout actual=%0d required=<2000", n);
        end
        @(negedge clk_i);
        ld_valid_i = 1'b0; ld_last_i = 1'b0;
    endtask

    task automatic send_image(input logic [63:0] entry);
        for (int i = 0; i < img_a_q.size(); i++)
            send_word(img_a_q[i], img_d_q[i], i == img_a_q.size() - 1, entry);
    endtask

    task automatic wait_end(input bit exp_err, input logic [31:0] exp_exit);
        int n;
        n = 0;
        while (!done_o && !error_o && n < 5000) begin
            @(negedge clk_i);
            n++;
        end
        check("end_reached", n < 5000, 1'b1);
        check("done_o", done_o, !exp_err);
        check("error_o", error_o, exp_err);
        check("exit_code", exit_code_o, exp_exit);
        repeat (2 * POLL_INTERVAL) @(negedge clk_i);
        check("plan_drained", exp_q.size(), 0);
        pulse_start();
        repeat (3 * POLL_INTERVAL) @(negedge clk_i);
        check("terminal_hold", {done_o, error_o, exit_code_o}, {!exp_err, exp_err, exp_exit});
    endtask

    // --------------------------------------------------------------- tests
    initial begin
        logic [31:0] ex;
        logic [63:0] entry;
        rst_ni = 1'b0; start_i = 1'b0; boot_mode_i = 2'd0; preload_mode_i = 2'd0;
        ld_valid_i = 1'b0; ld_addr_i = '0; ld_data_i = '0; ld_last_i = 1'b0; ld_entry_i = '0;

        // JTAG preload of 3 words, entry 0x8000_0000, scratch 3 -> exit 1.
        boot_mode_i = 2'd0; preload_mode_i = 2'd0;
        do_reset();
        entry = 64'h8000_0000;
        plan_load(3, entry);
        plan_poll(0, 32'd3, 0, ex);
        pulse_start();
        check("chan_jtag", chan_sel_o, 2'd0);
        send_image(entry);
        wait_end(0, ex);

        // UART preload, random size and entry, random non-EOC responses first.
        preload_mode_i = 2'd2;
        do_reset();
        entry = {$urandom, $urandom};
        plan_load($urandom_range(1, 4), entry);
        plan_poll($urandom_range(1, 3), $urandom, 1, ex);
        pulse_start();
        check("chan_uart", chan_sel_o, 2'd2);
        send_image(entry);
        wait_end(0, ex);

        // Serial link: nothing on the mem port during link training.
        preload_mode_i = 2'd1;
        do_reset();
        entry = {32'h0, $urandom};
        plan_load(2, entry);
        plan_poll(1, $urandom, 1, ex);
        pulse_start();
        check("chan_slink", chan_sel_o, 2'd1);
        fork
            send_image(entry);
            begin
                gap = 0;
                while (!mem_req_o && gap < SLINK_DELAY + 50) begin
                    @(negedge clk_i);
                    gap++;
                end
                check("slink_gap_ok", (gap > SLINK_DELAY) && (gap <= SLINK_DELAY + 2), 1'b1);
            end
        join
        wait_end(0, ex);

        // Autonomous boot 2: reads return 0,0,1 -> exit 0, first read after PollInterval.
        boot_mode_i = 2'd2; preload_mode_i = 2'($urandom_range(0, 3));
        do_reset();
        plan_poll(2, 32'd1, 0, ex);
        pulse_start();
        check("chan_auto", chan_sel_o, 2'd0);
        gap = 0;
        while (!mem_req_o && gap < 4 * POLL_INTERVAL) begin
            @(negedge clk_i);
            gap++;
        end
        check("first_poll_delay", gap, POLL_INTERVAL);
        wait_end(0, ex);

        // Autonomous boot 3 with a random exit code.
        boot_mode_i = 2'd3;
        do_reset();
        plan_poll($urandom_range(0, 2), $urandom, 1, ex);
        pulse_start();
        wait_end(0, ex);

        // SD boot and reserved preload mode are rejected on the next cycle.
        for (int m = 0; m < 2; m++) begin
            boot_mode_i    = (m == 0) ? 2'd1 : 2'd0;
            preload_mode_i = (m == 0) ? 2'd0 : 2'd3;
            do_reset();
            pulse_start();
            check("err_next_cycle", {error_o, exit_code_o}, {1'b1, 32'hFFFF_FFFF});
            wait_end(1, 32'hFFFF_FFFF);
        end

        // Grant held off for 10 cycles on the first image word.
        boot_mode_i = 2'd0; preload_mode_i = 2'd0;
        do_reset();
        entry = {32'h0, $urandom};
        plan_load(2, entry);
        plan_poll(0, $urandom, 0, ex);
        pulse_start();
        stall_next = 10;
        send_image(entry);
        wait_end(0, ex);

        // Reset dropped while a write is stalled mid-LOAD.
        do_reset();
        pulse_start();
        stall_next = 50;
        ld_valid_i = 1'b1; ld_addr_i = {$urandom, $urandom}; ld_data_i = $urandom; ld_last_i = 1'b0;
        @(negedge clk_i);
        ld_valid_i = 1'b0;
        @(negedge clk_i);
        check("mid_load_req", {mem_req_o, mem_we_o}, 2'b11);
        repeat (3) @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1 check("async_reset_outs", {chip_rst_no, boot_mode_o, chan_sel_o, mem_req_o, ld_ready_o,
                                      done_o, error_o, exit_code_o}, '0);
        do_reset();
        entry = {32'h0, $urandom};
        plan_load(1, entry);
        plan_poll(0, $urandom, 0, ex);
        pulse_start();
        send_image(entry);
        wait_end(0, ex);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5ms;
        failures++;
        $display("FAIL global_timeout actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "simulation time limit reached");
    end

endmodule
